// File: rtl/regfile_v3_pkg.sv
// regfile_v3_pkg: shared default sizes and zero-register index for regfile_v3
package regfile_v3_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_v3_sb.sv
// regfile_v3_sb: per-register busy scoreboard (issue sets, write clears, issue wins)
// Ports: clk, rst (async, active-high), wr_en/wr_addr clear a bit,
//        iss_en/iss_addr set a bit, busy_vec registered busy bits.
module regfile_v3_sb
  import regfile_v3_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);
  logic [2**ADDR_W-1:0] nxt;
  // Set is applied after clear so a same-cycle issue marks the new producer.
  always_comb begin
    nxt = busy_vec;
    if (wr_en) nxt[wr_addr] = 1'b0;
    if (iss_en) nxt[iss_addr] = 1'b1;
    nxt[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_vec <= '0;
    else busy_vec <= nxt;
endmodule

// File: rtl/regfile_v3.sv
// regfile_v3: multi-read-port register file with a busy-bit scoreboard
// Ports: clk, rst (async, active-high); rd_addr/rd_data/rd_busy packed per read port;
//        wr_en/wr_addr/wr_data write port; iss_en/iss_addr mark a destination pending;
//        busy_vec registered scoreboard bits.
// Macro REGFILE_V3_BYPASS_EN: forward same-cycle write data and busy-clear to reads.
module regfile_v3
  import regfile_v3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
  logic [DATA_W-1:0] regs [DEPTH];
  // Register 0 is reset to zero and never written, so it always reads 0.
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (wr_en && wr_addr != ZERO) regs[wr_addr] <= wr_data;
  regfile_v3_sb #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_V3_BYPASS_EN
    logic hit;
    // Forwarding is suppressed in reset so reads stay zero while rst is high.
    assign hit = wr_en && wr_addr == a && a != ZERO && !rst;
    assign rd_data[g*DATA_W +: DATA_W] = hit ? wr_data : regs[a];
    assign rd_busy[g] = hit ? (iss_en && iss_addr == a) : busy_vec[a];
`else
    assign rd_data[g*DATA_W +: DATA_W] = regs[a];
    assign rd_busy[g] = busy_vec[a];
`endif
  end
endmodule

// File: tb/tb_regfile_v3.sv
// tb_regfile_v3: scoreboard bench for regfile_v3 (default and 4-port/16-bit instances)
module tb_regfile_v3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_V3_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic wr_en, iss_en;
  logic [AW-1:0] wr_addr, iss_addr;
  logic [DW-1:0] wr_data;
  logic [2**AW-1:0] busy_vec;
  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [3:0] s_rd_busy;
  logic s_wr_en, s_iss_en;
  logic [2:0] s_wr_addr, s_iss_addr;
  logic [15:0] s_wr_data;
  logic [7:0] s_busy_vec;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int kind;
    int idx;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_v3 dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  regfile_v3 #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_s (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr), .busy_vec(s_busy_vec)
  );

  // kind: 0 rd_data port, 1 rd_busy port, 2 busy_vec bit, 3 small rd_data port, 4 small rd_busy port
  function automatic logic [31:0] actual(int kind, int idx);
    case (kind)
      0: return rd_data[idx*DW +: DW];
      1: return {31'b0, rd_busy[idx]};
      2: return {31'b0, busy_vec[idx]};
      3: return {16'b0, s_rd_data[idx*16 +: 16]};
      default: return {31'b0, s_rd_busy[idx]};
    endcase
  endfunction

  task automatic want(int kind, int idx, logic [31:0] e, string n);
    exp_t x;
    x.kind = kind;
    x.idx = idx;
    x.exp = e;
    x.name = n;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(int a0, int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(int a, logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic iss(int a);
    iss_en = 1'b1;
    iss_addr = AW'(a);
  endtask

  // Monitor: outputs are presented between edges; compare everything queued at each falling edge.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        got = actual(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, got, e.exp);
        end
      end
    end
  end

  initial begin
    idle();
    wr_addr = '0;
    wr_data = '0;
    iss_addr = '0;
    set_rd(5, 8);
    s_rd_addr = '0;
    s_wr_en = 1'b0;
    s_iss_en = 1'b0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_iss_addr = '0;
    want(0, 0, 0, "reset_rd0");
    want(2, 8, 0, "reset_bv8");
    cyc();
    rst = 1'b0;
    wr(5, 32'hDEADBEEF);
    cyc();
    idle();
    iss(8);
    want(0, 0, 32'hDEADBEEF, "wr5_data");
    want(1, 1, 0, "busy8_before_edge");
    cyc();
    idle();
    want(2, 8, 1, "busy_vec8_set");
    want(1, 1, 1, "rd_busy8_set");
    cyc();
    rst = 1'b1;
    wr(10, 32'h77);
    iss(11);
    set_rd(5, 10);
    want(0, 0, 0, "async_rst_rd5");
    want(2, 8, 0, "async_rst_bv8");
    want(1, 1, 0, "async_rst_rdbusy");
    want(0, 1, 0, "async_rst_rd10");
    cyc();
    rst = 1'b0;
    idle();
    set_rd(10, 11);
    cyc();
    want(0, 0, 0, "discard_wr10");
    want(2, 11, 0, "discard_iss11");
    cyc();
    wr(0, 32'h12345678);
    iss(0);
    set_rd(0, 0);
    cyc();
    idle();
    want(0, 0, 0, "reg0_reads_zero");
    want(2, 0, 0, "bv0_stays_zero");
    want(1, 0, 0, "rd_busy0_zero");
    cyc();
    iss(7);
    cyc();
    idle();
    set_rd(7, 7);
    want(1, 0, 1, "iss7_busy");
    cyc();
    wr(7, 32'hA5A5A5A5);
    cyc();
    idle();
    want(1, 0, 0, "wr7_busy_clear");
    want(0, 0, 32'hA5A5A5A5, "wr7_data");
    cyc();
    wr(9, 32'h55);
    iss(9);
    cyc();
    idle();
    set_rd(9, 9);
    want(0, 1, 32'h55, "same9_data");
    want(2, 9, 1, "same9_set_wins");
    want(0, 0, 32'h55, "dual_port_data");
    want(1, 0, 1, "dual_port_busy0");
    want(1, 1, 1, "dual_port_busy1");
    cyc();
    iss(9);
    cyc();
    idle();
    want(2, 9, 1, "waw9_stays_busy");
    cyc();
    wr(3, 32'h1111);
    cyc();
    idle();
    set_rd(0, 3);
    want(0, 1, 32'h1111, "wr3_nonbusy");
    want(2, 3, 0, "bv3_unchanged");
    cyc();
    wr(3, 32'hCAFE);
    want(0, 1, BYP ? 32'hCAFE : 32'h1111, "bypass3_data");
    want(1, 1, 0, "bypass3_busy");
    cyc();
    idle();
    want(0, 1, 32'hCAFE, "wr3_after_edge");
    cyc();
    wr(9, 32'h66);
    set_rd(9, 0);
    want(1, 0, BYP ? 0 : 1, "bypass9_busy");
    want(0, 0, BYP ? 32'h66 : 32'h55, "bypass9_data");
    cyc();
    idle();
    want(2, 9, 0, "clear9");
    want(0, 0, 32'h66, "wr9_data");
    cyc();
    s_wr_en = 1'b1;
    s_wr_addr = 3'd6;
    s_wr_data = 16'hBEEF;
    s_iss_en = 1'b1;
    s_iss_addr = 3'd6;
    cyc();
    s_wr_en = 1'b0;
    s_iss_en = 1'b0;
    s_rd_addr = {3'd6, 3'd6, 3'd6, 3'd6};
    for (int p = 0; p < 4; p++) begin
      want(3, p, 32'hBEEF, "small_rd6_data");
      want(4, p, 1, "small_rd6_busy");
    end
    cyc();
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_v3.md
REGFILE_V3 -- requirements
Module: regfile_v3

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-008 The block SHALL have port rd_busy  output  NUM_RD  per-port flag: the addressed register has a pending write.
REQ-009 The block SHALL have port wr_en  input  1  write strobe.
REQ-010 The block SHALL have port wr_addr  input  ADDR_W  write address.
REQ-011 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-012 The block SHALL have port iss_en  input  1  issue strobe: marks iss_addr as pending.
REQ-013 The block SHALL have port iss_addr  input  ADDR_W  destination being issued.
REQ-014 The block SHALL have port busy_vec  output  2**ADDR_W  registered scoreboard bits.

Function
REQ-015 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], zero added latency.
REQ-016 Writes SHALL update reg[wr_addr] on the rising clk edge when wr_en=1; latency 1 cycle.
REQ-017 Register 0 SHALL read as 0 always; writes to address 0 are discarded; busy_vec[0] is always 0.
REQ-018 iss_en=1 with iss_addr!=0 SHALL set busy_vec[iss_addr] on the next edge.
REQ-019 wr_en=1 with wr_addr!=0 SHALL clear busy_vec[wr_addr] on the next edge.
REQ-020 Simultaneous iss_en and wr_en to the same nonzero address: set SHALL win; data is still written, bit stays 1 (new producer).
REQ-021 iss_en to an already-busy register SHALL leave it busy (WAW permitted; no error).
REQ-022 wr_en to a non-busy register SHALL write data normally, with busy unchanged at 0.
REQ-023 rd_busy[i] SHALL equal busy_vec[rd_addr[i]], subject to REQ-029.
REQ-024 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-025 While rst=1, all registers SHALL asynchronously clear to 0 and all busy_vec bits SHALL clear to 0.
REQ-026 During reset, rd_data SHALL read 0 and rd_busy SHALL read 0 on every port.
REQ-027 An in-flight wr_en or iss_en coinciding with reset assertion SHALL be discarded.
REQ-028 Normal operation SHALL start at the first rising edge after rst deasserts.

Configuration
REQ-029 With macro REGFILE_V3_BYPASS_EN defined:
  - a read of nonzero address A while wr_en=1 and wr_addr=A SHALL return wr_data in the same cycle;
  - rd_busy for A SHALL read 0 unless iss_en=1 with iss_addr=A in that cycle.
REQ-030 Without REGFILE_V3_BYPASS_EN, reads SHALL return the pre-edge register contents and the registered busy bit only.

Structure
REQ-031 Shared package regfile_v3_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and the zero-register index constant.
REQ-032 The block SHALL contain one sub-module, regfile_v3_sb (scoreboard: busy bits, set/clear priority); the storage array and read muxes stay in regfile_v3.

Verification
REQ-033 Assert rst mid-run after writing reg5=0xDEADBEEF -> all rd_data=0 and busy_vec=0 immediately, without waiting for a clk edge.
REQ-034 Write reg0=0x12345678, then read reg0 -> 0x00000000; busy_vec[0] stays 0 after iss_addr=0.
REQ-035 iss reg7, then next cycle read reg7 -> rd_busy=1; wr reg7=0xA5A5A5A5 -> next cycle rd_busy=0, rd_data=0xA5A5A5A5.
REQ-036 Same cycle iss_en and wr_en on reg9 with data 0x55 -> after edge reg9=0x55 and busy_vec[9]=1.
REQ-037 With REGFILE_V3_BYPASS_EN, wr reg3=0xCAFE while port1 reads reg3 -> port1 returns 0xCAFE the same cycle; without the macro -> port1 returns the old value.
REQ-038 NUM_RD=4, ADDR_W=3, DATA_W=16: all four ports read reg6=0xBEEF -> all return 0xBEEF with identical rd_busy.
